apb_led_pwm: RTL

APB_LED_PWM -- requirements
Module: apb_led_pwm

---
 rtl/apb_led_pwm.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/apb_led_pwm.sv
// APB-programmable multi-channel LED PWM driver with optional per-channel blink.
// Blink logic (BLINK, BLINK_DIV, prescaler, phase) is built only when APB_LED_PWM_BLINK_EN is defined.
module apb_led_pwm #(
    parameter int NUM_LED  = 8,
    parameter int PWM_BITS = 8
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic [15:0]         PADDR,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    output logic [NUM_LED-1:0]  LED
);

    localparam logic [9:0] IDX_CTRL  = 10'h000;
    localparam logic [9:0] IDX_ON    = 10'h001;
    localparam logic [9:0] IDX_BLINK = 10'h002;
    localparam logic [9:0] IDX_DIV   = 10'h003;

    logic [9:0]          idx_s;
    logic                access_s;
    logic                wr_s;
    logic                hit_s;
    logic [31:0]         rdata_s;
    logic                unused_s;

    logic                en_q, en_d;
    logic [NUM_LED-1:0]  on_q, on_d;
    logic [PWM_BITS-1:0] duty_q [NUM_LED];
    logic [PWM_BITS-1:0] duty_d [NUM_LED];
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [NUM_LED-1:0]  led_q, led_d;
`ifdef APB_LED_PWM_BLINK_EN
    logic [NUM_LED-1:0]  blink_q, blink_d;
    logic [23:0]         div_q, div_d;
    logic [23:0]         pre_q, pre_d;
    logic                ph_q, ph_d;
`endif

    assign idx_s    = PADDR[11:2];
    assign access_s = PSEL & PENABLE;
    assign wr_s     = access_s & PWRITE;
    assign PREADY   = 1'b1;
    assign PSLVERR  = access_s & ~hit_s;
    assign PRDATA   = (access_s & ~PWRITE & hit_s) ? rdata_s : 32'h0000_0000;
    assign LED      = led_q;
    assign unused_s = ^{PADDR[15:12], PADDR[1:0], PWDATA};

    // Address decode and read mux
    always_comb begin
        hit_s   = 1'b0;
        rdata_s = 32'h0000_0000;
        case (idx_s)
            IDX_CTRL: begin
                hit_s   = 1'b1;
                rdata_s = {31'h0000_0000, en_q};
            end
            IDX_ON: begin
                hit_s   = 1'b1;
                rdata_s = 32'(on_q);
            end
`ifdef APB_LED_PWM_BLINK_EN
            IDX_BLINK: begin
                hit_s   = 1'b1;
                rdata_s = 32'(blink_q);
            end
            IDX_DIV: begin
                hit_s   = 1'b1;
                rdata_s = {8'h00, div_q};
            end
`endif
            default: begin
                for (int i = 0; i < NUM_LED; i++) begin
                    hit_s   = hit_s | (idx_s == 10'(16 + i));
                    rdata_s = rdata_s | ((idx_s == 10'(16 + i)) ? 32'(duty_q[i]) : 32'h0000_0000);
                end
            end
        endcase
    end

    // Register writes, PWM counter, blink prescaler and LED compare
    always_comb begin
        en_d  = en_q;
        on_d  = on_q;
        duty_d = duty_q;
`ifdef APB_LED_PWM_BLINK_EN
        blink_d = blink_q;
        div_d   = div_q;
`endif
        if (wr_s) begin
            case (idx_s)
                IDX_CTRL: en_d = PWDATA[0];
                IDX_ON:   on_d = PWDATA[NUM_LED-1:0];
`ifdef APB_LED_PWM_BLINK_EN
                IDX_BLINK: blink_d = PWDATA[NUM_LED-1:0];
                IDX_DIV:   div_d   = PWDATA[23:0];
`endif
                default: begin
                    for (int i = 0; i < NUM_LED; i++) begin
                        duty_d[i] = (idx_s == 10'(16 + i)) ? PWDATA[PWM_BITS-1:0] : duty_q[i];
                    end
                end
            endcase
        end else begin
            en_d = en_q;
        end

        cnt_d = en_q ? (cnt_q + PWM_BITS'(1'b1)) : '0;

`ifdef APB_LED_PWM_BLINK_EN
        // Writing BLINK_DIV restarts the blink pattern in its "on" phase
        if (!en_q || (wr_s && (idx_s == IDX_DIV))) begin
            pre_d = 24'h00_0000;
            ph_d  = 1'b1;
        end else if (pre_q == div_q) begin
            pre_d = 24'h00_0000;
            ph_d  = ~ph_q;
        end else begin
            pre_d = pre_q + 24'h00_0001;
            ph_d  = ph_q;
        end
`endif

        for (int i = 0; i < NUM_LED; i++) begin
`ifdef APB_LED_PWM_BLINK_EN
            led_d[i] = en_q & on_q[i] & (cnt_q < duty_q[i]) & (~blink_q[i] | ph_q);
`else
            led_d[i] = en_q & on_q[i] & (cnt_q < duty_q[i]);
`endif
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en_q  <= 1'b0;
            on_q  <= '0;
            cnt_q <= '0;
            led_q <= '0;
            for (int i = 0; i < NUM_LED; i++) begin
                duty_q[i] <= '0;
            end
`ifdef APB_LED_PWM_BLINK_EN
            blink_q <= '0;
            div_q   <= 24'h00_0000;
            pre_q   <= 24'h00_0000;
            ph_q    <= 1'b1;
`endif
        end else begin
            en_q   <= en_d;
            on_q   <= on_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            duty_q <= duty_d;
`ifdef APB_LED_PWM_BLINK_EN
            blink_q <= blink_d;
            div_q   <= div_d;
            pre_q   <= pre_d;
            ph_q    <= ph_d;
`endif
        end
    end

endmodule
